// File: rtl/hex_disp_sched.sv
// Time-shared hex decoder scan for eight 7-seg digits, with scroll/blink/leading-zero blanking.
// Latency: a digit refreshes every 8 cycles; no backpressure, enable=0 freezes all state.
module hex_disp_sched #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [1:0]  mode,
  input  logic        blank_lz,
  output logic [3:0]  dec_nib,
  input  logic [6:0]  dec_seg,
  output logic [55:0] hex_out,
  output logic        tick,
  output logic        frame_done
);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [31:0]      disp;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] tick_cnt;
  logic             blink_ph;
  logic [7:0]       upper_zero;
  logic             wrap;
  logic             blank_cur;

  // upper_zero[k]: nibbles k..7 of the working value are all zero
  always_comb begin
    upper_zero = '0;
    for (int k = 0; k < 8; k++) begin
      upper_zero[k] = ((disp >> (4 * k)) == 32'd0);
    end
  end

  assign dec_nib   = disp[{ptr, 2'b00} +: 4];
  assign wrap      = enable && (tick_cnt == TICK_LAST);
  assign blank_cur = ((mode == MODE_BLINK) && blink_ph) ||
                     (blank_lz && (ptr != 3'd0) && upper_zero[ptr]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp       <= '0;
      ptr        <= '0;
      tick_cnt   <= '0;
      blink_ph   <= 1'b0;
      hex_out    <= '1;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tick       <= wrap;
      frame_done <= enable && (ptr == 3'd7);
      if (enable) begin
        hex_out[int'(ptr) * 7 +: 7] <= blank_cur ? 7'h7F : dec_seg;
        ptr      <= ptr + 3'd1;
        tick_cnt <= wrap ? '0 : tick_cnt + CNT_W'(1);
      end
      // a load wins over a coincident tick: the pulse still fires but the step is dropped
      if (load) begin
        disp     <= data_in;
        tick_cnt <= '0;
        blink_ph <= 1'b0;
      end else if (wrap) begin
        case (mode)
          MODE_LEFT:  disp     <= {disp[27:0], disp[31:28]};
          MODE_RIGHT: disp     <= {disp[3:0], disp[31:4]};
          MODE_BLINK: blink_ph <= ~blink_ph;
          MODE_STATIC: ;
          default: ;
        endcase
      end
      if (mode != MODE_BLINK) blink_ph <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_disp_sched.sv
// Bench for hex_disp_sched: per-cycle reference model plus directed literal checks.
module tb_hex_disp_sched;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, blank_lz;
  logic [31:0] data_in;
  logic [1:0]  mode;
  logic [3:0]  dec_nib;
  logic [6:0]  dec_seg;
  logic [55:0] hex_out;
  logic        tick, frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hex_disp_sched #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in),
    .mode(mode), .blank_lz(blank_lz), .dec_nib(dec_nib), .dec_seg(dec_seg),
    .hex_out(hex_out), .tick(tick), .frame_done(frame_done)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign dec_seg = seg_of(dec_nib);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int k);
    return hex_out[7 * k +: 7];
  endfunction

  // Reference model: value-level view of what each digit must show
  logic [31:0] m_disp;
  int          m_ptr, m_cnt;
  bit          m_ph, m_tick, m_fd, m_valid = 1'b0;
  logic [6:0]  m_dig [8];
  bit          m_w, m_blk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_disp = 32'd0; m_ptr = 0; m_cnt = 0; m_ph = 1'b0;
      m_tick = 1'b0; m_fd = 1'b0; m_valid = 1'b1;
      for (int k = 0; k < 8; k++) m_dig[k] = 7'h7F;
    end else begin
      m_w   = enable && (m_cnt == TD - 1);
      m_blk = (mode == 2'b11 && m_ph) ||
              (blank_lz && m_ptr > 0 && (m_disp >> (4 * m_ptr)) == 32'd0);
      m_tick = m_w;
      m_fd   = enable && (m_ptr == 7);
      if (enable) begin
        m_dig[m_ptr] = m_blk ? 7'h7F : seg_of(m_disp[4 * m_ptr +: 4]);
        m_ptr = (m_ptr + 1) % 8;
        m_cnt = (m_cnt + 1) % TD;
      end
      if (load) begin
        m_disp = data_in; m_cnt = 0; m_ph = 1'b0;
      end else if (m_w) begin
        if (mode == 2'b01)      m_disp = (m_disp << 4) | (m_disp >> 28);
        else if (mode == 2'b10) m_disp = (m_disp >> 4) | (m_disp << 28);
        else if (mode == 2'b11) m_ph = !m_ph;
      end
      if (mode != 2'b11) m_ph = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [55:0] exp_hex;
    if (m_valid) begin
      for (int k = 0; k < 8; k++) exp_hex[7 * k +: 7] = m_dig[k];
      chk("model_hex_out", 64'(hex_out), 64'(exp_hex));
      chk("model_tick", 64'(tick), 64'(m_tick));
      chk("model_frame_done", 64'(frame_done), 64'(m_fd));
      chk("model_dec_nib", 64'(dec_nib), 64'(m_disp[4 * m_ptr +: 4]));
    end
  end

  task automatic do_load(input logic [31:0] v);
    load = 1'b1; data_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) begin got = 1'b1; break; end
    end
    if (!got) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    logic [55:0] saved;
    int found, cnt_dark, cnt_f;
    bit pulse;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); load = 1'($urandom); data_in = $urandom;
      mode = 2'($urandom); blank_lz = 1'($urandom);
      @(negedge clk);
    end
    chk("reset_hex_out", 64'(hex_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("reset_tick", 64'(tick), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);

    rst_n = 1'b1; enable = 1'b1; load = 1'b0; mode = 2'b00; blank_lz = 1'b0; data_in = '0;
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_done) begin found = i; break; end
    end
    chk("first_frame_done_cycle", 64'(found), 64'd8);

    // static display
    do_load(32'h0123_4567);
    repeat (8) @(negedge clk);
    chk("static_digit0", 64'(dig(0)), 64'h78);
    chk("static_digit7", 64'(dig(7)), 64'h40);
    saved = hex_out;
    repeat (12) @(negedge clk);
    chk("static_stable", 64'(hex_out), 64'(saved));

    // scroll left
    mode = 2'b01;
    do_load(32'h0000_0001);
    wait_tick("left_first_tick");
    mode = 2'b00;
    repeat (8) @(negedge clk);
    chk("left_digit1", 64'(dig(1)), 64'h79);
    chk("left_digit0", 64'(dig(0)), 64'h40);
    mode = 2'b01;
    for (int i = 0; i < 7; i++) wait_tick("left_wrap_tick");
    mode = 2'b00;
    repeat (8) @(negedge clk);
    chk("left_wrap_digit0", 64'(dig(0)), 64'h79);
    chk("left_wrap_digit1", 64'(dig(1)), 64'h40);

    // scroll right
    mode = 2'b10;
    do_load(32'h0000_0001);
    wait_tick("right_first_tick");
    mode = 2'b00;
    repeat (8) @(negedge clk);
    chk("right_digit7", 64'(dig(7)), 64'h79);
    chk("right_digit0", 64'(dig(0)), 64'h40);

    // blink: four digits lit with phase 0, four dark with phase 1
    mode = 2'b11;
    do_load(32'hFFFF_FFFF);
    repeat (8) @(negedge clk);
    cnt_dark = 0; cnt_f = 0;
    for (int k = 0; k < 8; k++) begin
      if (dig(k) == 7'h7F) cnt_dark++;
      if (dig(k) == 7'h0E) cnt_f++;
    end
    chk("blink_dark_count", 64'(cnt_dark), 64'd4);
    chk("blink_lit_count", 64'(cnt_f), 64'd4);

    // load on the tick edge: pulse still seen, phase stays 0
    do_load(32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    do_load(32'hFFFF_FFFF);
    chk("priority_tick_pulse", 64'(tick), 64'd1);
    repeat (4) @(negedge clk);
    cnt_f = 0;
    for (int k = 0; k < 8; k++) if (dig(k) == 7'h0E) cnt_f++;
    chk("priority_all_lit", 64'(cnt_f), 64'd8);

    // leading-zero blanking
    mode = 2'b00; blank_lz = 1'b1;
    do_load(32'h0000_00A0);
    repeat (8) @(negedge clk);
    cnt_dark = 0;
    for (int k = 2; k < 8; k++) if (dig(k) == 7'h7F) cnt_dark++;
    chk("lz_upper_dark", 64'(cnt_dark), 64'd6);
    chk("lz_digit1", 64'(dig(1)), 64'h08);
    chk("lz_digit0", 64'(dig(0)), 64'h40);
    do_load(32'h0000_0000);
    repeat (8) @(negedge clk);
    cnt_dark = 0;
    for (int k = 1; k < 8; k++) if (dig(k) == 7'h7F) cnt_dark++;
    chk("lz_zero_dark", 64'(cnt_dark), 64'd7);
    chk("lz_zero_digit0", 64'(dig(0)), 64'h40);
    blank_lz = 1'b0;

    // enable freeze at pointer 3 (nibble k holds k, so dec_nib tracks the pointer)
    do_load(32'h7654_3210);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (dec_nib == 4'd3) begin found = 1; break; end
      @(negedge clk);
    end
    chk("freeze_reach_ptr3", 64'(found), 64'd1);
    enable = 1'b0;
    saved = hex_out;
    pulse = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tick || frame_done) pulse = 1'b1;
    end
    chk("freeze_hex_out", 64'(hex_out), 64'(saved));
    chk("freeze_ptr", 64'(dec_nib), 64'd3);
    chk("freeze_no_pulses", 64'(pulse), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_ptr", 64'(dec_nib), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
